// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer/data widths, Gray code helpers and the
// read-side output-stage state type. Reused by both the read and write sides.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DATA_WIDTH = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic logic [FIFO_ADDR_WIDTH-1:0] bin2gray(input logic [FIFO_ADDR_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [FIFO_ADDR_WIDTH-1:0] gray2bin(input logic [FIFO_ADDR_WIDTH-1:0] gray);
        logic [FIFO_ADDR_WIDTH-1:0] bin;
        bin[FIFO_ADDR_WIDTH-1] = gray[FIFO_ADDR_WIDTH-1];
        for (int i = FIFO_ADDR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: write-pointer/memory inputs and the
// consumer handshake. master = surrounding logic, slave = fifo_rd_ctrl.
interface fifo_rd_ctrl_if
    import fifo_pkg::*;
#(
    parameter int addr_width = FIFO_ADDR_WIDTH
);

    logic [addr_width-1:0]      wptr_g;
    logic [FIFO_DATA_WIDTH-1:0] mem_rdata;
    logic                       rready;
    logic [addr_width-2:0]      raddress;
    logic [addr_width-1:0]      rptr_g;
    logic [FIFO_DATA_WIDTH-1:0] rdata;
    logic                       rvalid;
    logic                       rempty;
    logic                       raempty;
    logic [addr_width-1:0]      rlevel;

    modport master (
        output wptr_g, mem_rdata, rready,
        input  raddress, rptr_g, rdata, rvalid, rempty, raempty, rlevel
    );

    modport slave (
        input  wptr_g, mem_rdata, rready,
        output raddress, rptr_g, rdata, rvalid, rempty, raempty, rlevel
    );

endinterface

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock.
// Only one bit changes per source update, so a multi-bit bus is safe here.
module fifo_sync_2ff #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] meta_q, meta_d;
    logic [width-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: sequential state uses <= so both stages sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read controller: synchronizes the write pointer, tracks level and
// empty, and drives a registered valid/ready output stage with no bubbles.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int addr_width = FIFO_ADDR_WIDTH,
    parameter int aempty_lvl = 2
) (
    input logic           rclk,
    input logic           rrst,
    fifo_rd_ctrl_if.slave rd
);

    localparam logic [addr_width-1:0] AEMPTY_LVL = addr_width'(aempty_lvl);

    logic [addr_width-1:0]      wptr_g_s;
    logic [addr_width-1:0]      wbin_s;
    logic [addr_width-1:0]      rlevel;
    logic                       rempty;
    logic                       load;

    logic [addr_width-1:0]      rbin_q, rbin_d;
    logic [addr_width-1:0]      rptr_g_q, rptr_g_d;
    logic [FIFO_DATA_WIDTH-1:0] rdata_q, rdata_d;
    out_state_e                 state_q, state_d;

    fifo_sync_2ff #(.width(addr_width)) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (rd.wptr_g),
        .q   (wptr_g_s)
    );

    // All status derives from registered pointers; wptr_g never reaches an output directly.
    assign wbin_s = gray2bin(wptr_g_s);
    assign rlevel = wbin_s - rbin_q;
    assign rempty = (wbin_s == rbin_q);
    assign load   = !rempty && (state_q == OUT_EMPTY || rd.rready);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        rbin_d  = rbin_q;
        rdata_d = rdata_q;
        state_d = state_q;
        if (load) begin
            rbin_d  = rbin_q + addr_width'(1);
            rdata_d = rd.mem_rdata;
            state_d = OUT_FULL;
        end else if (state_q == OUT_FULL && rd.rready) begin
            state_d = OUT_EMPTY;
        end
        rptr_g_d = bin2gray(rbin_d);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_q   <= '0;
            rptr_g_q <= '0;
            rdata_q  <= '0;
            state_q  <= OUT_EMPTY;
        end else begin
            rbin_q   <= rbin_d;
            rptr_g_q <= rptr_g_d;
            rdata_q  <= rdata_d;
            state_q  <= state_d;
        end
    end

    assign rd.raddress = rbin_q[addr_width-2:0];
    assign rd.rptr_g   = rptr_g_q;
    assign rd.rdata    = rdata_q;
    assign rd.rvalid   = (state_q == OUT_FULL);
    assign rd.rempty   = rempty;
    assign rd.raempty  = (rlevel <= AEMPTY_LVL);
    assign rd.rlevel   = rlevel;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: stimulus pushes expected words, a monitor
// pops on each accepted transfer and also watches rptr_g steps and data hold.
module tb_fifo_rd_ctrl;

    logic rclk = 1'b0;
    logic rrst;

    fifo_rd_ctrl_if #(.addr_width(4)) ifc ();

    fifo_rd_ctrl #(.addr_width(4), .aempty_lvl(2)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .rd   (ifc)
    );

    always #5 rclk = ~rclk;

    logic [7:0] mem [8];
    logic [3:0] wbin_tb;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    assign ifc.mem_rdata = mem[ifc.raddress];

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_neg();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wbin_tb[2:0]] = d;
        exp_q.push_back(d);
        wbin_tb = wbin_tb + 4'd1;
    endtask

    task automatic publish();
        ifc.wptr_g = gray(wbin_tb);
    endtask

    task automatic wait_rvalid(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            next_neg();
            seen = ifc.rvalid;
        end
        check(name, 32'(seen), 1);
    endtask

    task automatic wait_drained(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            next_neg();
            done = (exp_q.size() == 0) && !ifc.rvalid;
        end
        check(name, 32'(done), 1);
        check({name, "_rlevel"}, 32'(ifc.rlevel), 0);
        check({name, "_rempty"}, 32'(ifc.rempty), 1);
    endtask

    task automatic apply_reset();
        rrst       = 1'b1;
        ifc.rready = 1'b0;
        wbin_tb    = '0;
        publish();
        exp_q.delete();
        repeat (2) @(posedge rclk);
        #1 rrst = 1'b0;
    endtask

    // Monitor: scoreboard pop, rptr_g one-bit steps, rdata hold under back-pressure.
    initial begin
        logic [3:0] prev_g;
        logic       hold_prev;
        logic [7:0] hold_val;
        logic [7:0] exp_v;
        prev_g    = '0;
        hold_prev = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge rclk);
            if (rrst) begin
                prev_g    = '0;
                hold_prev = 1'b0;
            end else begin
                if (ifc.rptr_g != prev_g) begin
                    check("rptr_g_hamming", $countones(ifc.rptr_g ^ prev_g), 1);
                    prev_g = ifc.rptr_g;
                end
                if (hold_prev) begin
                    check("hold_rvalid", 32'(ifc.rvalid), 1);
                    check("hold_rdata", 32'(ifc.rdata), 32'(hold_val));
                end
                hold_prev = ifc.rvalid && !ifc.rready;
                hold_val  = ifc.rdata;
                if (ifc.rvalid && ifc.rready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got 0x%0h expected no word", ifc.rdata);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("sb_data", 32'(ifc.rdata), 32'(exp_v));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        rrst       = 1'b1;
        ifc.rready = 1'b0;
        wbin_tb    = '0;
        publish();

        // Reset values, sampled while reset is held
        #2;
        check("rst_rempty",   32'(ifc.rempty), 1);
        check("rst_raempty",  32'(ifc.raempty), 1);
        check("rst_rvalid",   32'(ifc.rvalid), 0);
        check("rst_rlevel",   32'(ifc.rlevel), 0);
        check("rst_rptr_g",   32'(ifc.rptr_g), 0);
        check("rst_raddress", 32'(ifc.raddress), 0);
        check("rst_rdata",    32'(ifc.rdata), 0);
        repeat (2) @(posedge rclk);
        #1 rrst = 1'b0;
        next_neg();
        next_neg();
        check("idle_rempty", 32'(ifc.rempty), 1);
        check("idle_rvalid", 32'(ifc.rvalid), 0);
        check("idle_rptr_g", 32'(ifc.rptr_g), 0);

        // Single word: rempty after 2 edges, rvalid after 3
        @(posedge rclk); #1;
        push_word(8'hA1);
        publish();
        next_neg();
        check("lat1_rempty", 32'(ifc.rempty), 1);
        next_neg();
        check("lat2_rempty",  32'(ifc.rempty), 0);
        check("lat2_rlevel",  32'(ifc.rlevel), 1);
        check("lat2_raempty", 32'(ifc.raempty), 1);
        check("lat2_rvalid",  32'(ifc.rvalid), 0);
        next_neg();
        check("lat3_rvalid", 32'(ifc.rvalid), 1);
        check("lat3_rdata",  32'(ifc.rdata), 32'h A1);
        check("lat3_rptr_g", 32'(ifc.rptr_g), 32'h1);
        check("lat3_rempty", 32'(ifc.rempty), 1);
        @(posedge rclk); #1 ifc.rready = 1'b1;
        @(posedge rclk); #1 ifc.rready = 1'b0;
        next_neg();
        check("single_done_rvalid", 32'(ifc.rvalid), 0);

        // Full memory streamed with rready held: no bubble
        apply_reset();
        @(posedge rclk); #1;
        for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
        publish();
        ifc.rready = 1'b1;
        next_neg();
        next_neg();
        check("full_rlevel",  32'(ifc.rlevel), 8);
        check("full_raempty", 32'(ifc.raempty), 0);
        check("full_rvalid",  32'(ifc.rvalid), 0);
        for (int i = 0; i < 8; i++) begin
            next_neg();
            check("no_bubble_rvalid", 32'(ifc.rvalid), 1);
        end
        next_neg();
        check("stream_end_rvalid", 32'(ifc.rvalid), 0);
        check("stream_end_rlevel", 32'(ifc.rlevel), 0);
        check("stream_end_queue",  32'(exp_q.size()), 0);
        ifc.rready = 1'b0;

        // Toggling rready over a 5-word burst
        @(posedge rclk); #1;
        for (int i = 0; i < 5; i++) push_word(8'h30 + 8'(i));
        publish();
        for (int c = 0; c < 24; c++) begin
            @(posedge rclk); #1 ifc.rready = c[0];
        end
        ifc.rready = 1'b1;
        wait_drained("toggle_drain", 40);
        ifc.rready = 1'b0;

        // 20 words across the 15->0 pointer wrap
        @(posedge rclk); #1;
        for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
        publish();
        wait_rvalid("wrap_rvalid", 10);
        check("wrap_rlevel", 32'(ifc.rlevel), 7);
        check("wrap_rempty", 32'(ifc.rempty), 0);
        @(posedge rclk); #1 ifc.rready = 1'b1;
        wait_drained("wrap_drain1", 40);
        @(posedge rclk); #1;
        for (int i = 0; i < 8; i++) push_word(8'h48 + 8'(i));
        publish();
        wait_drained("wrap_drain2", 40);
        @(posedge rclk); #1;
        for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
        publish();
        wait_drained("wrap_drain3", 40);
        check("wrap_rptr_g", 32'(ifc.rptr_g), 32'(gray(wbin_tb)));
        ifc.rready = 1'b0;

        // Reset mid-transfer with a held word and level 3
        @(posedge rclk); #1;
        for (int i = 0; i < 4; i++) push_word(8'h60 + 8'(i));
        publish();
        wait_rvalid("pre_rst_rvalid", 10);
        check("pre_rst_rlevel",  32'(ifc.rlevel), 3);
        check("pre_rst_raempty", 32'(ifc.raempty), 0);
        @(posedge rclk); #2 rrst = 1'b1;
        #1;
        check("midrst_rvalid",   32'(ifc.rvalid), 0);
        check("midrst_rdata",    32'(ifc.rdata), 0);
        check("midrst_rempty",   32'(ifc.rempty), 1);
        check("midrst_raempty",  32'(ifc.raempty), 1);
        check("midrst_rlevel",   32'(ifc.rlevel), 0);
        check("midrst_rptr_g",   32'(ifc.rptr_g), 0);
        check("midrst_raddress", 32'(ifc.raddress), 0);
        exp_q.delete();
        wbin_tb = '0;
        publish();
        @(posedge rclk); #1 rrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_neg();
            check("post_rst_idle", 32'({ifc.rvalid, ifc.rempty}), 32'b01);
        end

        // Clean restart; level 2 sits exactly on the almost-empty threshold
        @(posedge rclk); #1;
        for (int i = 0; i < 3; i++) push_word(8'h5A + 8'(i));
        publish();
        wait_rvalid("restart_rvalid", 10);
        check("restart_rlevel",  32'(ifc.rlevel), 2);
        check("restart_raempty", 32'(ifc.raempty), 1);
        @(posedge rclk); #1 ifc.rready = 1'b1;
        wait_drained("restart_drain", 20);
        ifc.rready = 1'b0;

        repeat (2) @(posedge rclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter: addr_width, default 4, pointer width including wrap bit; memory depth SHALL be 2^(addr_width-1) = 8.
REQ-002 Parameter: aempty_lvl, default 2, almost-empty threshold in entries.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: rclk in 1, rrst in 1.
REQ-004 wptr_g  in  addr_width  Gray write pointer from the write domain, unsynchronized.
REQ-005 mem_rdata  in  8  Memory read data, combinational from raddress.
REQ-006 rready  in  1  Consumer accepts rdata this cycle.
REQ-007 raddress  out  addr_width-1  Memory read address (low bits of binary read pointer).
REQ-008 rptr_g  out  addr_width  Registered Gray read pointer to the write domain.
REQ-009 rdata  out  8  Output data register.
REQ-010 rvalid  out  1  rdata holds an unconsumed word.
REQ-011 rempty  out  1  No unread entries remain in memory.
REQ-012 raempty  out  1  Memory level <= aempty_lvl.
REQ-013 rlevel  out  addr_width  Memory entries unread, 0..8.

Function
REQ-014 wptr_g SHALL pass through a 2-flop synchronizer on rclk; the synced value SHALL be Gray-to-binary converted to wbin_s.
REQ-015 rbin SHALL be the binary read pointer; rlevel = (wbin_s - rbin) mod 2^addr_width, combinational from registers.
REQ-016 rempty = (wbin_s == rbin); raempty = (rlevel <= aempty_lvl).
REQ-017 The output stage is a two-state FSM: OUT_EMPTY (rvalid=0) and OUT_FULL (rvalid=1).
REQ-018 The load condition is !rempty && (!rvalid || rready); on load: rdata <= mem_rdata, rbin <= rbin+1, rvalid <= 1.
REQ-019 In OUT_FULL with rready=1 and rempty=1, the FSM SHALL go to OUT_EMPTY and rvalid <= 0; rdata holds its value.
REQ-020 In OUT_FULL with rready=0, rdata and rvalid SHALL hold, and rbin SHALL NOT advance.
REQ-021 Simultaneous consume and load in OUT_FULL SHALL stay in OUT_FULL and deliver the next word with no bubble.
REQ-022 rptr_g SHALL be registered as the Gray code of the next rbin in the same cycle rbin updates; at most 1 bit changes per cycle.
REQ-023 Pointer wrap: rbin 15->0 wraps modulo 2^addr_width, and the empty/level math remains correct across the wrap.
REQ-024 Latency: a write visible on wptr_g is reflected in rempty after 2 rclk edges and in rvalid after 3 rclk edges.
REQ-025 rbin SHALL never pass wbin_s; a read when rempty=1 SHALL be impossible by construction.

Reset
REQ-026 When rrst=1, asynchronously: rbin=0, rptr_g=0, sync flops=0, rdata=0, rvalid=0, FSM=OUT_EMPTY.
REQ-027 With those reset values: rempty=1, raempty=1, rlevel=0, raddress=0.
REQ-028 Reset asserted mid-transfer SHALL discard the held word with no partial state remaining.
REQ-029 After rrst deasserts, the first load SHALL occur no earlier than the first rclk edge.

Structure
REQ-030 A shared package fifo_pkg SHALL hold the bin2gray and gray2bin functions, FIFO_ADDR_WIDTH=4 and FIFO_DATA_WIDTH=8; the write side SHALL reuse them.
REQ-031 The 2-flop synchronizer SHALL be a sub-module fifo_sync_2ff, parameterized by width, with async active-high reset.
REQ-032 No combinational path SHALL exist from wptr_g to any output.

Verification
REQ-033 Reset, then wptr_g=0 -> rempty=1, rvalid=0, rlevel=0, rptr_g=0000.
REQ-034 Memory preloaded with 0xA1 at address 0, wptr_g=0001, rready=0 -> rempty=0 after 2 clocks; rvalid=1 and rdata=0xA1 at clock 3; rptr_g=0001; rempty=1 again.
REQ-035 Memory holding 0x10..0x17, wptr_g=gray(8)=1100, rready=1 held -> 8 consecutive words 0x10..0x17 with no bubble; then rvalid=0 and rlevel=0.
REQ-036 rready toggled 1/0 during a 5-word burst -> no word lost or duplicated; rdata is stable while rvalid=1 and rready=0.
REQ-037 20 words streamed with wptr wrapping 15->0 -> data order preserved; rptr_g has a 1-bit Hamming distance between successive values; rlevel is correct at the wrap.
REQ-038 rrst pulsed while rvalid=1 and rlevel=3 -> all outputs return to REQ-026/REQ-027 values within the same cycle.
